// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    // $clog2 that never returns 0, so derived vector widths stay legal.
    function automatic int unsigned clog2_safe(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Beat-counter width for the default MAX_BURST of 4.
    localparam int unsigned DEF_MAX_BURST = 4;
    localparam int unsigned BEAT_W        = clog2_safe(DEF_MAX_BURST) + 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                any_req,
    output logic [ID_WIDTH-1:0] winner
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] shifted;
    logic [NUM_REQ-1:0]   rotated;
    int                   offset;
    int                   sum;

    // Rotate requests so ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        dbl     = {req, req};
        shifted = dbl >> ptr;
        rotated = shifted[NUM_REQ-1:0];
        any_req = |req;
        offset  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i;
            end
        end
        sum = int'(ptr) + offset;
        if (sum >= int'(NUM_REQ)) begin
            sum = sum - int'(NUM_REQ);
        end
        winner = ID_WIDTH'(sum);
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_data,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id
);

    localparam int unsigned BeatW = clog2_safe(MAX_BURST) + 1;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [BeatW-1:0]      beat_cnt_q, beat_cnt_d;

    logic                  arb_any;
    logic [ID_WIDTH-1:0]   arb_winner;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;
    logic                  end_burst;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .any_req (arb_any),
        .winner  (arb_winner)
    );

    // Select the current owner's request signals.
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        sel_valid = req_valid[grant_id_q];
        sel_last  = req_last[grant_id_q];
        sel_data  = data_arr[grant_id_q];
        xfer      = (state_q == StBurst) && sel_valid && !fifo_full;
    end

    // State and grant registers; reset drops any grant at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state: grant in IDLE, count beats and detect end of burst in BURST.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        end_burst  = 1'b0;
        case (state_q)
            StIdle: begin
                // almost_full only blocks new grants, never an active burst.
                if (arb_any && !fifo_almost_full) begin
                    state_d    = StBurst;
                    grant_id_d = arb_winner;
                    beat_cnt_d = '0;
                end
            end
            StBurst: begin
                if (!sel_valid) begin
                    end_burst = 1'b1;
                end else if (xfer) begin
                    if (sel_last || (beat_cnt_q == BeatW'(MAX_BURST - 1))) begin
                        end_burst = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BeatW'(1);
                    end
                end
                // A fifo_full stall falls through here: grant and count hold.
                if (end_burst) begin
                    state_d    = StIdle;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) ?
                                 '0 : grant_id_q + ID_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: only the owner sees ready, and writes never happen while full.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = {grant_id_q, sel_data};
        grant_valid  = (state_q == StBurst);
        grant_id     = grant_id_q;
        if (state_q == StBurst) begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_wr_en            = xfer;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a cycle-level behavioural model.
module tb_fifo_write_arbiter;

    localparam int NumReq    = 4;
    localparam int DataWidth = 8;
    localparam int MaxBurst  = 4;
    localparam int IdWidth   = 2;
    localparam int NumPhases = 6;
    localparam int PhaseLen  = 300;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NumReq-1:0]           req_valid;
    logic [NumReq-1:0]           req_last;
    logic [NumReq*DataWidth-1:0] req_data;
    logic [NumReq-1:0]           req_ready;
    logic                        fifo_full;
    logic                        fifo_almost_full;
    logic                        fifo_wr_en;
    logic [IdWidth+DataWidth-1:0] fifo_wr_data;
    logic                        grant_valid;
    logic [IdWidth-1:0]          grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus biases per phase, in percent: valid, last, full, almost_full, reset.
    int p_valid [NumPhases] = '{90, 100, 95, 80, 40, 90};
    int p_last  [NumPhases] = '{20,   0, 10, 30, 20, 25};
    int p_full  [NumPhases] = '{ 0,   0, 30,  0, 10, 15};
    int p_af    [NumPhases] = '{ 0,   0,  0, 50, 10, 15};
    int p_rst   [NumPhases] = '{ 0,   0,  0,  0,  0,  3};

    // Model state: who owns the port, beats written this burst, next search start.
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_ptr;

    fifo_write_arbiter #(
        .NUM_REQ    (NumReq),
        .DATA_WIDTH (DataWidth),
        .MAX_BURST  (MaxBurst),
        .ID_WIDTH   (IdWidth)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_last         (req_last),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .grant_valid      (grant_valid),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic end_model_burst();
        m_busy  = 1'b0;
        m_ptr   = (m_owner + 1) % NumReq;
        m_beats = 0;
    endtask

    initial begin
        int exp_ready;
        int exp_data;
        bit exp_wr;
        int cyc;

        rst              = 1'b1;
        req_valid        = '0;
        req_last         = '0;
        req_data         = '0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_ptr   = 0;
        repeat (2) @(posedge clk);
        cyc = 0;

        for (int ph = 0; ph < NumPhases; ph++) begin
            for (int c = 0; c < PhaseLen; c++) begin
                @(negedge clk);
                // Keep the first post-reset cycle quiet so the reset state is observed alone.
                if (cyc == 0) begin
                    rst = 1'b0;
                end else begin
                    rst              = chance(p_rst[ph]);
                    fifo_full        = chance(p_full[ph]);
                    fifo_almost_full = chance(p_af[ph]);
                    for (int i = 0; i < NumReq; i++) begin
                        req_valid[i] = chance(p_valid[ph]);
                        req_last[i]  = chance(p_last[ph]);
                        req_data[i*DataWidth +: DataWidth] = DataWidth'($urandom);
                    end
                end
                cyc++;
                #1;

                exp_ready = (m_busy && !fifo_full) ? (1 << m_owner) : 0;
                exp_wr    = m_busy && req_valid[m_owner] && !fifo_full;
                exp_data  = (m_owner << DataWidth) |
                            int'(req_data[m_owner*DataWidth +: DataWidth]);

                check("grant_valid", 32'(grant_valid), 32'(m_busy));
                check("grant_id", 32'(grant_id), 32'(m_owner));
                check("req_ready", 32'(req_ready), 32'(exp_ready));
                check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
                if (exp_wr) begin
                    check("fifo_wr_data", 32'(fifo_wr_data), 32'(exp_data));
                end

                // Advance the model to the state after the coming rising edge.
                if (rst) begin
                    m_busy  = 1'b0;
                    m_owner = 0;
                    m_beats = 0;
                    m_ptr   = 0;
                end else if (!m_busy) begin
                    if (req_valid != '0 && !fifo_almost_full) begin
                        for (int k = NumReq - 1; k >= 0; k--) begin
                            if (req_valid[(m_ptr + k) % NumReq]) begin
                                m_owner = (m_ptr + k) % NumReq;
                            end
                        end
                        m_busy  = 1'b1;
                        m_beats = 0;
                    end
                end else if (!req_valid[m_owner]) begin
                    end_model_burst();
                end else if (!fifo_full) begin
                    m_beats++;
                    if (req_last[m_owner] || m_beats == MaxBurst) begin
                        end_model_burst();
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
